// File: rtl/uart_host_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_host_ctrl_if
// Groups the UART register-bus signals and the byte-stream client signals
// handled by uart_host_ctrl.
//   master : the controller side (drives the bus strobes, tx_ready, rx_*)
//   slave  : the environment side (register block + byte-stream client)
// Signals:
//   wb_adr_o  register address        wb_dat_o  write data
//   wb_dat_i  read data (comb.)       wb_we_o   write strobe
//   wb_re_o   read strobe
//   tx_data   byte to transmit        tx_valid  tx_data valid
//   tx_ready  accept pulse
//   rx_data   received byte           rx_valid  rx_data valid pulse
//   rx_err    line-error pulse
// -----------------------------------------------------------------------------
interface uart_host_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [7:0]            wb_dat_o;
  logic [7:0]            wb_dat_i;
  logic                  wb_we_o;
  logic                  wb_re_o;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_err;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_re_o,
    output tx_ready, rx_data, rx_valid, rx_err,
    input  wb_dat_i, tx_data, tx_valid
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_re_o,
    input  tx_ready, rx_data, rx_valid, rx_err,
    output wb_dat_i, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// -----------------------------------------------------------------------------
// uart_host_ctrl
// Polled bus initiator for the UART register block. After reset it programs
// DLL/DLM (through DLAB), LCR, FCR and IER, then loops reading LSR. A set
// data-ready bit triggers an RB read onto the rx stream; otherwise an empty
// transmit holding register plus a pending tx byte triggers a TR write.
// Ports:
//   clk       clock, rising edge
//   wb_rst_i  asynchronous active-high reset
//   bus       uart_host_ctrl_if.master (register bus + byte streams)
//   init_done high once the init sequence has completed
// -----------------------------------------------------------------------------
module uart_host_ctrl #(
  parameter int          ADDR_WIDTH = 3,
  parameter logic [15:0] DIVISOR    = 16'd27,
  parameter logic [7:0]  LCR_INIT   = 8'h03,
  parameter logic [7:0]  FCR_INIT   = 8'hC0,
  parameter int          GAP        = 2
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  uart_host_ctrl_if.master bus,
  output logic             init_done
);

  localparam logic [3:0] S_INIT_DLAB = 4'd0;
  localparam logic [3:0] S_INIT_DLL  = 4'd1;
  localparam logic [3:0] S_INIT_DLM  = 4'd2;
  localparam logic [3:0] S_INIT_LCR  = 4'd3;
  localparam logic [3:0] S_INIT_FCR  = 4'd4;
  localparam logic [3:0] S_INIT_IER  = 4'd5;
  localparam logic [3:0] S_POLL      = 4'd6;
  localparam logic [3:0] S_RD_RB     = 4'd7;
  localparam logic [3:0] S_WR_TR     = 4'd8;
  localparam logic [3:0] S_WAIT      = 4'd9;

  // The wait state is entered on the edge that raises the strobe, so the
  // counter covers the strobe cycle's closing edge plus the idle cycles.
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  localparam logic [ADDR_WIDTH-1:0] A_RB_TR = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_IE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_FC    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_LC    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_LS    = ADDR_WIDTH'(5);

  logic [3:0]            r_state;
  logic [3:0]            r_ret;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [7:0]            r_dat;
  logic                  r_we;
  logic                  r_re;
  logic                  r_tx_ready;
  logic [7:0]            r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_err;
  logic                  r_init_done;
  logic                  r_lsr_dr;
  logic                  r_lsr_thre;

  logic [ADDR_WIDTH-1:0] w_adr;
  logic [7:0]            w_dat;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_lsr_dr;
  logic                  w_lsr_thre;
  logic [3:0]            w_next;

  // Access decode for the current issue state.
  always_comb begin
    w_adr = r_adr;
    w_dat = r_dat;
    w_wr  = 1'b0;
    w_rd  = 1'b0;
    case (r_state)
      S_INIT_DLAB: begin w_adr = A_LC;    w_dat = LCR_INIT | 8'h80; w_wr = 1'b1; end
      S_INIT_DLL:  begin w_adr = A_RB_TR; w_dat = DIVISOR[7:0];     w_wr = 1'b1; end
      S_INIT_DLM:  begin w_adr = A_IE;    w_dat = DIVISOR[15:8];    w_wr = 1'b1; end
      S_INIT_LCR:  begin w_adr = A_LC;    w_dat = LCR_INIT & 8'h7F; w_wr = 1'b1; end
      S_INIT_FCR:  begin w_adr = A_FC;    w_dat = FCR_INIT | 8'h06; w_wr = 1'b1; end
      S_INIT_IER:  begin w_adr = A_IE;    w_dat = 8'h00;            w_wr = 1'b1; end
      S_POLL:      begin w_adr = A_LS;    w_rd = 1'b1; end
      S_RD_RB:     begin w_adr = A_RB_TR; w_rd = 1'b1; end
      S_WR_TR:     begin w_adr = A_RB_TR; w_dat = bus.tx_data;      w_wr = 1'b1; end
      default: ;
    endcase
  end

  // With GAP=1 the poll decision falls on the same edge as the LSR capture,
  // so use the live read data while the read strobe is still up.
  assign w_lsr_dr   = r_re ? bus.wb_dat_i[0] : r_lsr_dr;
  assign w_lsr_thre = r_re ? bus.wb_dat_i[5] : r_lsr_thre;

  // State that follows the shared wait.
  always_comb begin
    w_next = S_POLL;
    case (r_ret)
      S_INIT_DLAB: w_next = S_INIT_DLL;
      S_INIT_DLL:  w_next = S_INIT_DLM;
      S_INIT_DLM:  w_next = S_INIT_LCR;
      S_INIT_LCR:  w_next = S_INIT_FCR;
      S_INIT_FCR:  w_next = S_INIT_IER;
      S_POLL: begin
        if (w_lsr_dr)
          w_next = S_RD_RB;
        else if (w_lsr_thre && bus.tx_valid)
          w_next = S_WR_TR;
        else
          w_next = S_POLL;
      end
      default:     w_next = S_POLL;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_INIT_DLAB;
      r_ret       <= S_INIT_DLAB;
      r_cnt       <= 4'd0;
      r_adr       <= '0;
      r_dat       <= 8'h00;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
      r_init_done <= 1'b0;
      r_lsr_dr    <= 1'b0;
      r_lsr_thre  <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_state)
        S_INIT_DLAB, S_INIT_DLL, S_INIT_DLM, S_INIT_LCR, S_INIT_FCR,
        S_INIT_IER, S_POLL, S_RD_RB, S_WR_TR: begin
          r_adr      <= w_adr;
          r_dat      <= w_dat;
          r_we       <= w_wr;
          r_re       <= w_rd;
          r_tx_ready <= (r_state == S_WR_TR);
          r_ret      <= r_state;
          r_cnt      <= GAP_LOAD;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // r_re is high only during the strobe cycle of a read.
          if (r_re && (r_ret == S_POLL)) begin
            r_lsr_dr   <= bus.wb_dat_i[0];
            r_lsr_thre <= bus.wb_dat_i[5];
            r_rx_err   <= |{bus.wb_dat_i[7], bus.wb_dat_i[4:1]};
          end
          if (r_re && (r_ret == S_RD_RB)) begin
            r_rx_data  <= bus.wb_dat_i;
            r_rx_valid <= 1'b1;
          end
          if (r_cnt == 4'd0) begin
            r_state <= w_next;
            if (r_ret == S_INIT_IER)
              r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_INIT_DLAB;
      endcase
    end
  end

  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_dat;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_re_o  = r_re;
  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_err   = r_rx_err;
  assign init_done    = r_init_done;

endmodule

// File: tb/tb_uart_host_ctrl.sv
module tb_uart_host_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  logic init_done;
  logic init_done1;
  logic [7:0] lsr_val;
  logic [7:0] rb_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_host_ctrl_if #(.ADDR_WIDTH(3)) bus  ();
  uart_host_ctrl_if #(.ADDR_WIDTH(3)) bus1 ();

  uart_host_ctrl #(
    .ADDR_WIDTH(3), .DIVISOR(16'h0127), .LCR_INIT(8'h03),
    .FCR_INIT(8'hC0), .GAP(2)
  ) dut (
    .clk(clk), .wb_rst_i(rst), .bus(bus.master), .init_done(init_done)
  );

  uart_host_ctrl #(
    .ADDR_WIDTH(3), .DIVISOR(16'h0127), .LCR_INIT(8'h03),
    .FCR_INIT(8'hC0), .GAP(1)
  ) dut1 (
    .clk(clk), .wb_rst_i(rst1), .bus(bus1.master), .init_done(init_done1)
  );

  // Register block model: LS returns lsr_val, anything else returns rb_val.
  always_comb begin
    bus.wb_dat_i = (bus.wb_adr_o == 3'd5) ? lsr_val : rb_val;
  end
  assign bus1.wb_dat_i = 8'h00;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] exp_adr [6];
  logic [7:0] exp_dat [6];

  initial begin
    int c_we, c_re, c_txr, c_rxv, c_both;
    exp_adr[0] = 3'd3; exp_dat[0] = 8'h83;
    exp_adr[1] = 3'd0; exp_dat[1] = 8'h27;
    exp_adr[2] = 3'd1; exp_dat[2] = 8'h01;
    exp_adr[3] = 3'd3; exp_dat[3] = 8'h03;
    exp_adr[4] = 3'd2; exp_dat[4] = 8'hC6;
    exp_adr[5] = 3'd1; exp_dat[5] = 8'h00;

    rst = 1'b1; rst1 = 1'b1;
    lsr_val = 8'h00; rb_val = 8'h00;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    bus1.tx_valid = 1'b1; bus1.tx_data = 8'hFF;

    // Reset state
    repeat (3) tick();
    chk("rst_we",   32'(bus.wb_we_o), 0);
    chk("rst_re",   32'(bus.wb_re_o), 0);
    chk("rst_adr",  32'(bus.wb_adr_o), 0);
    chk("rst_dat",  32'(bus.wb_dat_o), 0);
    chk("rst_txr",  32'(bus.tx_ready), 0);
    chk("rst_rxv",  32'(bus.rx_valid), 0);
    chk("rst_rxe",  32'(bus.rx_err), 0);
    chk("rst_done", 32'(init_done), 0);

    rst = 1'b0;
    lsr_val = 8'h60; bus.tx_valid = 1'b1; bus.tx_data = 8'hA5;

    // Init sequence: one write every 3 cycles, init_done after edge 18
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("init%0d_we", i),  32'(bus.wb_we_o), 1);
      chk($sformatf("init%0d_re", i),  32'(bus.wb_re_o), 0);
      chk($sformatf("init%0d_adr", i), 32'(bus.wb_adr_o), 32'(exp_adr[i]));
      chk($sformatf("init%0d_dat", i), 32'(bus.wb_dat_o), 32'(exp_dat[i]));
      chk($sformatf("init%0d_txr", i), 32'(bus.tx_ready), 0);
      tick();
      chk($sformatf("init%0d_gap", i), 32'(bus.wb_we_o), 0);
      tick();
      chk($sformatf("init%0d_done", i), 32'(init_done), (i == 5) ? 1 : 0);
    end

    // Edge 19: LS poll; edge 22: TR write of A5
    tick();
    chk("poll1_re",  32'(bus.wb_re_o), 1);
    chk("poll1_adr", 32'(bus.wb_adr_o), 5);
    repeat (3) tick();
    chk("tx1_we",  32'(bus.wb_we_o), 1);
    chk("tx1_adr", 32'(bus.wb_adr_o), 0);
    chk("tx1_dat", 32'(bus.wb_dat_o), 32'h A5);
    chk("tx1_txr", 32'(bus.tx_ready), 1);
    $display("[TB] tx byte A5 written to TR");
    lsr_val = 8'h61; rb_val = 8'h3C; bus.tx_data = 8'h5A;
    tick();
    chk("tx1_txr_off", 32'(bus.tx_ready), 0);
    chk("tx1_we_off",  32'(bus.wb_we_o), 0);

    // Edge 25: poll returning 61 -> RB read has priority over pending tx
    repeat (2) tick();
    chk("poll2_re",  32'(bus.wb_re_o), 1);
    chk("poll2_adr", 32'(bus.wb_adr_o), 5);
    tick();
    chk("poll2_noerr", 32'(bus.rx_err), 0);
    repeat (2) tick();
    chk("rb1_re",  32'(bus.wb_re_o), 1);
    chk("rb1_adr", 32'(bus.wb_adr_o), 0);
    chk("rb1_we",  32'(bus.wb_we_o), 0);
    chk("rb1_txr", 32'(bus.tx_ready), 0);
    tick();
    chk("rb1_rxv",  32'(bus.rx_valid), 1);
    chk("rb1_rxd",  32'(bus.rx_data), 32'h3C);
    $display("[TB] rx byte %0h read from RB", bus.rx_data);
    lsr_val = 8'h0B; rb_val = 8'h77;
    tick();
    chk("rb1_rxv_off", 32'(bus.rx_valid), 0);

    // Edge 31: poll returning 0B -> rx_err pulse, then RB read
    tick();
    chk("poll3_re",  32'(bus.wb_re_o), 1);
    chk("poll3_adr", 32'(bus.wb_adr_o), 5);
    tick();
    chk("poll3_err", 32'(bus.rx_err), 1);
    lsr_val = 8'h60;
    tick();
    chk("poll3_err_off", 32'(bus.rx_err), 0);
    tick();
    chk("rb2_re",  32'(bus.wb_re_o), 1);
    chk("rb2_adr", 32'(bus.wb_adr_o), 0);
    chk("rb2_txr", 32'(bus.tx_ready), 0);
    tick();
    chk("rb2_rxv", 32'(bus.rx_valid), 1);
    chk("rb2_rxd", 32'(bus.rx_data), 32'h77);
    $display("[TB] rx byte %0h read from RB after line error", bus.rx_data);

    // Edge 37: poll 60 -> edge 40: TR write of 5A
    repeat (2) tick();
    chk("poll4_re", 32'(bus.wb_re_o), 1);
    repeat (3) tick();
    chk("tx2_we",  32'(bus.wb_we_o), 1);
    chk("tx2_dat", 32'(bus.wb_dat_o), 32'h5A);
    chk("tx2_txr", 32'(bus.tx_ready), 1);
    $display("[TB] tx byte 5A written to TR");
    bus.tx_data = 8'hC3;

    // Reset during the WR_TR gap with a new byte pending
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_we",   32'(bus.wb_we_o), 0);
    chk("mrst_re",   32'(bus.wb_re_o), 0);
    chk("mrst_adr",  32'(bus.wb_adr_o), 0);
    chk("mrst_dat",  32'(bus.wb_dat_o), 0);
    chk("mrst_txr",  32'(bus.tx_ready), 0);
    chk("mrst_done", 32'(init_done), 0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("reinit%0d_txr", k), 32'(bus.tx_ready), 0);
      chk($sformatf("reinit%0d_done", k), 32'(init_done), (k == 18) ? 1 : 0);
      if (k == 1) begin
        chk("reinit_we",  32'(bus.wb_we_o), 1);
        chk("reinit_adr", 32'(bus.wb_adr_o), 3);
        chk("reinit_dat", 32'(bus.wb_dat_o), 32'h83);
      end
    end
    tick();
    chk("poll5_re", 32'(bus.wb_re_o), 1);
    repeat (3) tick();
    chk("tx3_we",  32'(bus.wb_we_o), 1);
    chk("tx3_dat", 32'(bus.wb_dat_o), 32'hC3);
    chk("tx3_txr", 32'(bus.tx_ready), 1);
    $display("[TB] pending tx byte C3 written after re-init");
    bus.tx_valid = 1'b0;

    // GAP=1 instance, LS always 00
    c_we = 0; c_re = 0; c_txr = 0; c_rxv = 0; c_both = 0;
    rst1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus1.wb_we_o) c_we++;
      if (bus1.wb_re_o) c_re++;
      if (bus1.tx_ready) c_txr++;
      if (bus1.rx_valid) c_rxv++;
      if (bus1.wb_we_o && bus1.wb_re_o) c_both++;
      if (k == 11) chk("g1_done_pre", 32'(init_done1), 0);
      if (k == 12) chk("g1_done", 32'(init_done1), 1);
      if (k > 12) chk($sformatf("g1_poll%0d", k), 32'(bus1.wb_re_o), 32'(k % 2));
    end
    chk("g1_we_cnt",   32'(c_we), 6);
    chk("g1_re_cnt",   32'(c_re), 14);
    chk("g1_txr_cnt",  32'(c_txr), 0);
    chk("g1_rxv_cnt",  32'(c_rxv), 0);
    chk("g1_both_cnt", 32'(c_both), 0);
    $display("[TB] GAP=1 idle loop: %0d writes, %0d reads", c_we, c_re);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
